// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Command-level controller for the shared registered ALU. Parses byte
//   commands from the RX path, loads operands/function, pulses the ALU enable,
//   waits for the registered ALU result and returns it to the TX path as two
//   bytes, least-significant byte first.
//
//   Commands:  CC A B FUN  -> load new operands, then execute
//              DD FUN      -> execute on stored operands
//
// Ports
//   CLK            in   system clock
//   RST            in   asynchronous, active-low reset
//   rx_data        in   command/operand byte, qualified by rx_valid
//   rx_valid       in   one-cycle strobe, one byte per strobe
//   alu_a/alu_b    out  registered ALU operands
//   alu_fun        out  registered ALU function code
//   alu_en         out  one-cycle ALU enable pulse per operation
//   alu_res        in   registered ALU result (2*DATA_WIDTH)
//   alu_res_valid  in   registered ALU result strobe
//   tx_data        out  result byte to TX
//   tx_valid       out  tx_data valid, held until accepted (tx_busy low)
//   tx_busy        in   TX cannot accept this cycle
//   busy           out  high whenever the FSM is not in IDLE
//   err            out  one-cycle pulse on protocol error, timeout or overrun
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     rx_data,
   input  logic                      rx_valid,
   output logic [DATA_WIDTH-1:0]     alu_a,
   output logic [DATA_WIDTH-1:0]     alu_b,
   output logic [3:0]                alu_fun,
   output logic                      alu_en,
   input  logic [2*DATA_WIDTH-1:0]   alu_res,
   input  logic                      alu_res_valid,
   output logic [DATA_WIDTH-1:0]     tx_data,
   output logic                      tx_valid,
   input  logic                      tx_busy,
   output logic                      busy,
   output logic                      err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [DATA_WIDTH-1:0] CMD_LOAD = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_EXEC = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      EXEC,
      WAIT_RES,
      SEND_LO,
      SEND_HI
   } state_t;

   state_t                  state;
   logic [TW-1:0]           timer;
   logic [TW-1:0]           timer_inc;
   logic [DATA_WIDTH-1:0]   res_hi;
   logic                    fun_ok;
   logic                    in_flight;

   assign timer_inc = timer + TW'(1);

   // Function codes 0x0..0xE are legal; 0xF and any upper-nibble bit are not.
   assign fun_ok = (rx_data[3:0] != 4'hF) && (rx_data[DATA_WIDTH-1:4] == '0);

   // States in which an incoming byte cannot be consumed (overrun).
   assign in_flight = (state == EXEC) || (state == WAIT_RES) ||
                      (state == SEND_LO) || (state == SEND_HI);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         alu_a    <= '0;
         alu_b    <= '0;
         alu_fun  <= '0;
         alu_en   <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         timer    <= '0;
         res_hi   <= '0;
      end else begin
         alu_en <= 1'b0;
         err    <= 1'b0;

         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data == CMD_LOAD) begin
                     state <= GET_A;
                     busy  <= 1'b1;
                  end else if (rx_data == CMD_EXEC) begin
                     state <= GET_FUN;
                     busy  <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end

            GET_A: begin
               if (rx_valid) begin
                  alu_a <= rx_data;
                  state <= GET_B;
               end
            end

            GET_B: begin
               if (rx_valid) begin
                  alu_b <= rx_data;
                  state <= GET_FUN;
               end
            end

            GET_FUN: begin
               if (rx_valid) begin
                  if (fun_ok) begin
                     alu_fun <= rx_data[3:0];
                     alu_en  <= 1'b1;
                     state   <= EXEC;
                  end else begin
                     err   <= 1'b1;
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end

            EXEC: begin
               timer <= '0;
               state <= WAIT_RES;
            end

            WAIT_RES: begin
               if (alu_res_valid) begin
                  // Low byte goes straight out; only the high byte is kept.
                  tx_data  <= alu_res[DATA_WIDTH-1:0];
                  res_hi   <= alu_res[2*DATA_WIDTH-1:DATA_WIDTH];
                  tx_valid <= 1'b1;
                  state    <= SEND_LO;
               end else if (timer_inc == TW'(TIMEOUT)) begin
                  err   <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  timer <= timer_inc;
               end
            end

            SEND_LO: begin
               if (!tx_busy) begin
                  tx_data <= res_hi;
                  state   <= SEND_HI;
               end
            end

            SEND_HI: begin
               if (!tx_busy) begin
                  tx_valid <= 1'b0;
                  state    <= IDLE;
                  busy     <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               busy     <= 1'b0;
               tx_valid <= 1'b0;
            end
         endcase

         // Bytes arriving while an operation is in flight are dropped.
         if (rx_valid && in_flight) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Self-checking bench for alu_cmd_sequencer. A small registered ALU stub
//   answers alu_en one cycle later (ADD/SUB/MUL, XOR otherwise). A table of
//   command vectors is applied in a loop, followed by hand-written sequences
//   for TX back-pressure, result timeout, overrun and mid-send reset.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

   localparam int DW      = 8;
   localparam int TIMEOUT = 15;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic [DW-1:0]   rx_data = '0;
   logic            rx_valid = 1'b0;
   logic [DW-1:0]   alu_a;
   logic [DW-1:0]   alu_b;
   logic [3:0]      alu_fun;
   logic            alu_en;
   logic [2*DW-1:0] alu_res;
   logic            alu_res_valid;
   logic [DW-1:0]   tx_data;
   logic            tx_valid;
   logic            tx_busy = 1'b0;
   logic            busy;
   logic            err;

   logic            stub_off = 1'b0;

   int checks = 0;
   int errors = 0;

   alu_cmd_sequencer #(
      .DATA_WIDTH (DW),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .alu_a         (alu_a),
      .alu_b         (alu_b),
      .alu_fun       (alu_fun),
      .alu_en        (alu_en),
      .alu_res       (alu_res),
      .alu_res_valid (alu_res_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_busy       (tx_busy),
      .busy          (busy),
      .err           (err)
   );

   always #5 CLK = ~CLK;

   // Registered ALU stub
   function automatic logic [2*DW-1:0] alu_model(input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [3:0]    f);
      case (f)
         4'h0:    return {8'h00, a} + {8'h00, b};
         4'h1:    return {8'h00, a} - {8'h00, b};
         4'h2:    return a * b;
         default: return {8'h00, a ^ b};
      endcase
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         alu_res       <= '0;
         alu_res_valid <= 1'b0;
      end else begin
         alu_res_valid <= alu_en && !stub_off;
         if (alu_en) alu_res <= alu_model(alu_a, alu_b, alu_fun);
      end
   end

   // Output monitor, sampled on the falling edge
   int            cyc = 0;
   int            en_total = 0;
   int            err_total = 0;
   int            en_cyc = 0;
   int            txv_cyc = 0;
   logic          txv_d = 1'b0;
   logic [DW-1:0] txq[$];

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (alu_en) begin
         en_total = en_total + 1;
         en_cyc   = cyc;
      end
      if (err) err_total = err_total + 1;
      if (tx_valid && !txv_d) txv_cyc = cyc;
      txv_d = tx_valid;
      if (tx_valid && !tx_busy) txq.push_back(tx_data);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] tx_at(input int idx);
      if (idx < txq.size()) return txq[idx];
      return 8'hxx;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(posedge CLK); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge CLK); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      do begin
         @(negedge CLK);
         k = k + 1;
      end while (busy && k < 60);
      check({name, "_idle"}, {31'd0, busy}, 32'd0);
      repeat (2) @(negedge CLK);
   endtask

   typedef struct {
      int        n;
      logic [7:0] b0, b1, b2, b3;
      logic [7:0] ea, eb;
      logic [3:0] ef;
      int        en;
      int        er;
      int        ntx;
      logic [7:0] lo, hi;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int base_en, base_err, base_tx, last_cyc;
      int en_k, err_k, bad;
      logic [7:0] bytes[4];

      vecs[0] = '{4, 8'hCC, 8'h05, 8'h03, 8'h00, 8'h05, 8'h03, 4'h0, 1, 0, 2, 8'h08, 8'h00};
      vecs[1] = '{4, 8'hCC, 8'h10, 8'h04, 8'h02, 8'h10, 8'h04, 4'h2, 1, 0, 2, 8'h40, 8'h00};
      vecs[2] = '{2, 8'hDD, 8'h01, 8'h00, 8'h00, 8'h10, 8'h04, 4'h1, 1, 0, 2, 8'h0C, 8'h00};
      vecs[3] = '{1, 8'h55, 8'h00, 8'h00, 8'h00, 8'h10, 8'h04, 4'h1, 0, 1, 0, 8'h00, 8'h00};
      vecs[4] = '{4, 8'hCC, 8'h01, 8'h01, 8'h0F, 8'h01, 8'h01, 4'h1, 0, 1, 0, 8'h00, 8'h00};
      vecs[5] = '{4, 8'hCC, 8'h02, 8'h03, 8'hF2, 8'h02, 8'h03, 4'h1, 0, 1, 0, 8'h00, 8'h00};
      vecs[6] = '{2, 8'hDD, 8'h0E, 8'h00, 8'h00, 8'h02, 8'h03, 4'hE, 1, 0, 2, 8'h01, 8'h00};

      // Reset state
      #1;
      check("rst_alu_a",    {24'd0, alu_a},   32'd0);
      check("rst_alu_b",    {24'd0, alu_b},   32'd0);
      check("rst_alu_fun",  {28'd0, alu_fun}, 32'd0);
      check("rst_outs",     {28'd0, alu_en, tx_valid, busy, err}, 32'd0);
      check("rst_tx_data",  {24'd0, tx_data}, 32'd0);
      repeat (3) @(posedge CLK);
      #1 RST = 1'b1;

      // Table-driven command vectors
      for (int i = 0; i < 7; i++) begin
         base_en  = en_total;
         base_err = err_total;
         base_tx  = txq.size();
         bytes[0] = vecs[i].b0; bytes[1] = vecs[i].b1;
         bytes[2] = vecs[i].b2; bytes[3] = vecs[i].b3;
         for (int j = 0; j < vecs[i].n; j++) send_byte(bytes[j]);
         last_cyc = cyc;
         wait_idle($sformatf("v%0d", i));
         check($sformatf("v%0d_alu_a", i),   {24'd0, alu_a},   {24'd0, vecs[i].ea});
         check($sformatf("v%0d_alu_b", i),   {24'd0, alu_b},   {24'd0, vecs[i].eb});
         check($sformatf("v%0d_alu_fun", i), {28'd0, alu_fun}, {28'd0, vecs[i].ef});
         check($sformatf("v%0d_en_cnt", i),  en_total - base_en,   vecs[i].en);
         check($sformatf("v%0d_err_cnt", i), err_total - base_err, vecs[i].er);
         check($sformatf("v%0d_tx_cnt", i),  txq.size() - base_tx, vecs[i].ntx);
         if (vecs[i].ntx == 2) begin
            check($sformatf("v%0d_tx_lo", i), {24'd0, tx_at(base_tx)},     {24'd0, vecs[i].lo});
            check($sformatf("v%0d_tx_hi", i), {24'd0, tx_at(base_tx + 1)}, {24'd0, vecs[i].hi});
            check($sformatf("v%0d_lat_en", i), en_cyc - last_cyc, 1);
            check($sformatf("v%0d_lat_tx", i), txv_cyc - en_cyc, 2);
         end
      end

      // TX back-pressure: CC FF FF 02 -> 0xFE01, held for 20 cycles
      tx_busy  = 1'b1;
      base_tx  = txq.size();
      send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
      en_k = 0;
      while (!tx_valid && en_k < 10) begin
         @(negedge CLK);
         en_k = en_k + 1;
      end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (!tx_valid || tx_data !== 8'h01) bad = bad + 1;
      end
      check("bp_hold_stable", bad, 0);
      check("bp_tx_data", {24'd0, tx_data}, 32'h01);
      @(posedge CLK); #1 tx_busy = 1'b0;
      wait_idle("bp");
      check("bp_tx_cnt", txq.size() - base_tx, 2);
      check("bp_tx_lo", {24'd0, tx_at(base_tx)},     32'h01);
      check("bp_tx_hi", {24'd0, tx_at(base_tx + 1)}, 32'hFE);
      check("bp_tx_valid_low", {31'd0, tx_valid}, 32'd0);

      // Result timeout: stub never answers
      stub_off = 1'b1;
      base_tx  = txq.size();
      base_err = err_total;
      send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
      en_k  = 0;
      err_k = 0;
      for (int k = 1; k <= 25; k++) begin
         @(negedge CLK);
         if (alu_en && en_k == 0)  en_k = k;
         if (err && err_k == 0)    err_k = k;
      end
      check("to_en_cycle", en_k, 1);
      check("to_err_delay", err_k - en_k, TIMEOUT + 1);
      check("to_err_cnt", err_total - base_err, 1);
      check("to_idle", {31'd0, busy}, 32'd0);
      check("to_no_tx", txq.size() - base_tx, 0);

      // Overrun during WAIT_RES: byte dropped, FSM unaffected
      base_err = err_total;
      base_en  = en_total;
      send_byte(8'hCC); send_byte(8'h07); send_byte(8'h08); send_byte(8'h00);
      @(posedge CLK);
      send_byte(8'h77);
      wait_idle("ovr");
      check("ovr_err_cnt", err_total - base_err, 2);
      check("ovr_en_cnt", en_total - base_en, 1);
      check("ovr_alu_a", {24'd0, alu_a}, 32'h07);
      check("ovr_alu_b", {24'd0, alu_b}, 32'h08);
      stub_off = 1'b0;

      // Reset during SEND_LO
      tx_busy = 1'b1;
      send_byte(8'hCC); send_byte(8'h33); send_byte(8'h44); send_byte(8'h00);
      en_k = 0;
      while (!tx_valid && en_k < 10) begin
         @(negedge CLK);
         en_k = en_k + 1;
      end
      check("rs_in_send", {31'd0, tx_valid}, 32'd1);
      @(posedge CLK); #1 RST = 1'b0;
      #1;
      check("rs_outs",    {28'd0, alu_en, tx_valid, busy, err}, 32'd0);
      check("rs_alu_a",   {24'd0, alu_a},   32'd0);
      check("rs_alu_b",   {24'd0, alu_b},   32'd0);
      check("rs_alu_fun", {28'd0, alu_fun}, 32'd0);
      check("rs_tx_data", {24'd0, tx_data}, 32'd0);
      @(posedge CLK); #1;
      RST     = 1'b1;
      tx_busy = 1'b0;
      base_tx = txq.size();
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
      wait_idle("rs");
      check("rs_tx_cnt", txq.size() - base_tx, 2);
      check("rs_tx_lo", {24'd0, tx_at(base_tx)},     32'h08);
      check("rs_tx_hi", {24'd0, tx_at(base_tx + 1)}, 32'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "global timeout");
   end

endmodule
